keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/scan_tick_gen.sv | 30 +++
 rtl/keypad_scanner.sv | 162 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state type, column reset pattern and parameter defaults.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] COL_RESET    = 4'b1110;
    localparam int         SCAN_DIV_DEF = 100000;
    localparam int         DEBOUNCE_DEF = 4;

    // Lowest-index active-low row wins when several rows are low.
    function automatic logic [1:0] low_row_idx(input logic [3:0] row_l);
        logic [1:0] idx;
        if (!row_l[0])      idx = 2'd0;
        else if (!row_l[1]) idx = 2'd1;
        else if (!row_l[2]) idx = 2'd2;
        else                idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running period counter; tick is high on the last cycle of each
// SCAN_DIV-cycle period. Ports: clk, rst_L (async active-low), tick.
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst_L,
    output logic tick
);

    localparam int            CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates column strobes, debounces press/release.
// Ports: clk, rst_L, row_L[3:0] in; col_L, key_code, key_valid, key_held out.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = SCAN_DIV_DEF,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic [3:0] row_L,
    output logic [3:0] col_L,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] N        = 4'(DEBOUNCE_SCANS);
    localparam bit         ONE_SCAN = (DEBOUNCE_SCANS == 1);

    logic       tick;
    logic [3:0] row_meta_q, row_sync_q;
    state_e     state_q, state_d;
    logic [3:0] col_l_q, col_l_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [1:0] cand_col_q, cand_col_d;
    logic [1:0] cand_row_q, cand_row_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;

    logic       row_hi;
    logic       any_low;
    logic [1:0] low_idx;
    logic [3:0] cnt_inc;
    logic [3:0] col_next;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_L(rst_L),
        .tick (tick)
    );

    assign row_hi   = row_sync_q[cand_row_q];
    assign any_low  = ~&row_sync_q;
    assign low_idx  = low_row_idx(row_sync_q);
    assign cnt_inc  = cnt_q + 4'd1;
    assign col_next = {col_l_q[2:0], col_l_q[3]};

    always_comb begin
        state_d     = state_q;
        col_l_d     = col_l_q;
        col_idx_d   = col_idx_q;
        cand_col_d  = cand_col_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        unique case (state_q)
            ST_SCAN: begin
                if (tick && any_low) begin
                    cand_col_d = col_idx_q;
                    cand_row_d = low_idx;
                    cnt_d      = 4'd1;
                    if (ONE_SCAN) begin
                        key_code_d  = {col_idx_q, low_idx};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = ST_HELD;
                    end else begin
                        state_d = ST_DEBOUNCE;
                    end
                end else if (tick) begin
                    col_l_d   = col_next;
                    col_idx_d = col_idx_q + 2'd1;
                end
            end
            ST_DEBOUNCE: begin
                // Acceptance happens the cycle after the count completes;
                // a tick can never fall on that cycle since SCAN_DIV >= 4.
                if (cnt_q >= N) begin
                    key_code_d  = {cand_col_q, cand_row_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = ST_HELD;
                end else if (tick && row_hi) begin
                    state_d   = ST_SCAN;
                    col_l_d   = col_next;
                    col_idx_d = col_idx_q + 2'd1;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (tick && row_hi) begin
                    cnt_d = 4'd1;
                    if (ONE_SCAN) begin
                        key_held_d = 1'b0;
                        state_d    = ST_SCAN;
                        col_l_d    = col_next;
                        col_idx_d  = col_idx_q + 2'd1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (tick && row_hi) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= N) begin
                        key_held_d = 1'b0;
                        state_d    = ST_SCAN;
                        col_l_d    = col_next;
                        col_idx_d  = col_idx_q + 2'd1;
                    end
                end else if (tick) begin
                    state_d = ST_HELD;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            state_q     <= ST_SCAN;
            col_l_q     <= COL_RESET;
            col_idx_q   <= 2'd0;
            cand_col_q  <= 2'd0;
            cand_row_q  <= 2'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_L;
            row_sync_q  <= row_meta_q;
            state_q     <= state_d;
            col_l_q     <= col_l_d;
            col_idx_q   <= col_idx_d;
            cand_col_q  <= cand_col_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_L     = col_l_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a 16-switch keypad model.
// Expected key codes are queued at stimulus time and popped on key_valid.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic [3:0] row_L;
    logic [3:0] col_L;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // pressed[{col,row}] is a closed switch.
    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    logic [3:0]  rot[4];
    logic [3:0]  prev_code = '0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          code_changes = 0;
    int          held_drops = 0;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .row_L    (row_L),
        .col_L    (col_L),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low if any closed switch on it
    // sits in a column currently strobed low.
    always_comb begin
        row_L = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_L[c] && pressed[c*4+r]) row_L[r] = 1'b0;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every accepted press must match the head of the queue.
    always @(negedge clk) begin
        if (!rst_L) begin
            prev_code = '0;
        end else begin
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_valid: got code %0h expected none",
                             key_code);
                end else begin
                    check("valid_code", key_code, exp_q.pop_front());
                    check("held_on_valid", key_held, 1'b1);
                end
            end else if (key_code != prev_code) begin
                code_changes++;
            end
            prev_code = key_code;
        end
    end

    initial begin
        rot[0] = 4'b1110;
        rot[1] = 4'b1101;
        rot[2] = 4'b1011;
        rot[3] = 4'b0111;

        // Reset values and idle rotation
        cycles(3);
        check("rst_col", col_L, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        rst_L = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            check("idle_rot", col_L, rot[(n/4)%4]);
        end

        // One-tick bounce on col 0 / row 0 right after reset
        rst_L = 1'b0;
        cycles(2);
        rst_L = 1'b1;
        pressed[0] = 1'b1;
        cycles(4);
        pressed[0] = 1'b0;
        cycles(2);
        check("bounce_frozen", col_L, 4'b1110);
        cycles(2);
        check("bounce_adv1", col_L, 4'b1101);
        cycles(4);
        check("bounce_adv2", col_L, 4'b1011);
        check("bounce_held", key_held, 1'b0);

        // Clean press col 2 / row 1
        cycles(4);
        pressed[9] = 1'b1;
        exp_q.push_back(4'b1001);
        cycles(40);
        check("clean_code", key_code, 4'b1001);
        check("clean_held", key_held, 1'b1);
        pressed[9] = 1'b0;
        cycles(6);
        check("clean_held_rel", key_held, 1'b1);
        cycles(4);
        check("clean_cleared", key_held, 1'b0);
        cycles(8);

        // Two rows in col 0, then a col 3 press while held
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        exp_q.push_back(4'b0000);
        cycles(40);
        pressed[15] = 1'b1;
        cycles(30);
        check("multi_code", key_code, 4'b0000);
        check("multi_held", key_held, 1'b1);
        pressed = '0;
        cycles(20);

        // Release glitch of one tick while held
        pressed[6] = 1'b1;
        exp_q.push_back(4'd6);
        cycles(40);
        held_drops = 0;
        pressed[6] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!key_held) held_drops++;
        end
        pressed[6] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!key_held) held_drops++;
        end
        check("glitch_held_drops", held_drops, 0);
        check("glitch_code", key_code, 4'd6);
        pressed = '0;
        cycles(20);

        // Reset mid-press, key re-detected afterwards
        pressed[5] = 1'b1;
        exp_q.push_back(4'd5);
        cycles(40);
        rst_L = 1'b0;
        #1;
        check("midrst_col", col_L, 4'b1110);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_held", key_held, 1'b0);
        check("midrst_code", key_code, 4'h0);
        cycles(3);
        rst_L = 1'b1;
        exp_q.push_back(4'd5);
        cycles(40);
        check("redetect_held", key_held, 1'b1);
        pressed = '0;
        cycles(20);

        // Randomized presses with optional leading bounces
        for (int it = 0; it < 12; it++) begin
            logic [3:0] k;
            logic [3:0] b;
            k = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                pressed[b] = 1'b1;
                cycles(4);
                pressed[b] = 1'b0;
                cycles(8);
            end
            pressed[k] = 1'b1;
            exp_q.push_back(k);
            cycles(40 + $urandom_range(0, 20));
            check("rand_code", key_code, k);
            pressed[k] = 1'b0;
            cycles(14 + $urandom_range(0, 6));
        end

        cycles(30);
        check("queue_drained", exp_q.size(), 0);
        check("code_changes", code_changes, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
